// File: rtl/tcc_ctrl_pkg.sv
// Shared types and constants for the accumulator-machine control unit.
// Opcode and ALU encodings are fixed by the instruction set.
package tcc_ctrl_pkg;

   localparam int DATA_WIDTH   = 11;
   localparam int OPCODE_WIDTH = 4;

   typedef enum logic [OPCODE_WIDTH-1:0] {
      HLT  = 4'd0,
      STO  = 4'd1,
      LD   = 4'd2,
      LDI  = 4'd3,
      ADD  = 4'd4,
      ADDI = 4'd5,
      SUB  = 4'd6,
      SUBI = 4'd7,
      IN   = 4'd8,
      OUT  = 4'd9,
      BEQ  = 4'd10,
      BLT  = 4'd11,
      JMP  = 4'd12,
      NOP  = 4'd15
   } opcode_t;

   typedef enum logic [1:0] {
      ALU_PASS_B = 2'b00,
      ALU_ADD    = 2'b01,
      ALU_SUB    = 2'b10,
      ALU_RSVD   = 2'b11
   } alu_op_t;

   typedef enum logic [2:0] {
      S_FETCH    = 3'd0,
      S_DECODE   = 3'd1,
      S_EXEC     = 3'd2,
      S_WAIT_IN  = 3'd3,
      S_WAIT_OUT = 3'd4,
      S_HALT     = 3'd5
   } ctrl_state_t;

   typedef struct packed {
      logic    in_ready;
      logic    out_valid;
      logic    ir_write;
      logic    pc_increment;
      logic    pc_load;
      logic    sel_A;
      logic    sel_B;
      alu_op_t alu_op;
      logic    acc_write;
      logic    mem_write;
      logic    halted;
   } ctrl_out_t;

   // Immediate forms take operand B from the sign-extended immediate.
   function automatic logic op_is_imm(input logic [OPCODE_WIDTH-1:0] op);
      return (op == LDI) || (op == ADDI) || (op == SUBI);
   endfunction

   function automatic alu_op_t op_alu(input logic [OPCODE_WIDTH-1:0] op);
      alu_op_t r;
      case (op)
         ADD, ADDI: r = ALU_ADD;
         SUB, SUBI: r = ALU_SUB;
         default:   r = ALU_PASS_B;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/control_unit_fsm_decoder.sv
// Combinational map from FSM state, latched opcode and live flags to the
// datapath control vector.
module control_decoder
   import tcc_ctrl_pkg::*;
(
   input  ctrl_state_t                 i_state,
   input  logic [OPCODE_WIDTH-1:0]     i_opcode,
   input  logic                        i_acc_zero,
   input  logic                        i_acc_negative,
   input  logic                        i_in_valid,
   output ctrl_out_t                   o_ctrl
);

   always_comb begin
      o_ctrl = '0;
      case (i_state)
         S_FETCH: begin
            o_ctrl.ir_write     = 1'b1;
            o_ctrl.pc_increment = 1'b1;
         end
         // Operand select is set up a cycle early so the synchronous memory
         // read issued here lands in EXEC.
         S_DECODE: begin
            o_ctrl.sel_B  = op_is_imm(i_opcode);
            o_ctrl.alu_op = op_alu(i_opcode);
         end
         S_EXEC: begin
            o_ctrl.sel_B  = op_is_imm(i_opcode);
            o_ctrl.alu_op = op_alu(i_opcode);
            case (i_opcode)
               LD, LDI, ADD, ADDI, SUB, SUBI: o_ctrl.acc_write = 1'b1;
               STO:     o_ctrl.mem_write = 1'b1;
               JMP:     o_ctrl.pc_load   = 1'b1;
               BEQ:     o_ctrl.pc_load   = i_acc_zero;
               BLT:     o_ctrl.pc_load   = i_acc_negative;
               default: ;
            endcase
         end
         S_WAIT_IN: begin
            o_ctrl.in_ready  = 1'b1;
            o_ctrl.sel_A     = 1'b1;
            o_ctrl.acc_write = i_in_valid;
         end
         S_WAIT_OUT: o_ctrl.out_valid = 1'b1;
         S_HALT:     o_ctrl.halted    = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/control_unit_fsm.sv
// Multi-cycle control unit: holds state and latched opcode; all output
// decoding lives in control_decoder.
module control_unit_fsm #(
   parameter int DATA_WIDTH   = tcc_ctrl_pkg::DATA_WIDTH,
   parameter int OPCODE_WIDTH = tcc_ctrl_pkg::OPCODE_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] instruction_in,
   input  logic                  acc_zero,
   input  logic                  acc_negative,
   input  logic                  in_valid,
   input  logic                  out_ready,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic                  ir_write,
   output logic                  pc_increment,
   output logic                  pc_load,
   output logic                  sel_A,
   output logic                  sel_B,
   output logic [1:0]            alu_op,
   output logic                  acc_write,
   output logic                  mem_write,
   output logic                  halted
);
   import tcc_ctrl_pkg::*;

   ctrl_state_t               r_state;
   ctrl_state_t               w_state_nxt;
   logic [OPCODE_WIDTH-1:0]   r_opcode;
   ctrl_out_t                 w_ctrl;
   ctrl_out_t                 w_out;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= S_FETCH;
         r_opcode <= NOP;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_FETCH)
            r_opcode <= instruction_in[DATA_WIDTH-1 -: OPCODE_WIDTH];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_FETCH:  w_state_nxt = S_DECODE;
         S_DECODE: begin
            case (r_opcode)
               HLT:     w_state_nxt = S_HALT;
               IN:      w_state_nxt = S_WAIT_IN;
               OUT:     w_state_nxt = S_WAIT_OUT;
               default: w_state_nxt = S_EXEC;
            endcase
         end
         S_EXEC:     w_state_nxt = S_FETCH;
         S_WAIT_IN:  if (in_valid)  w_state_nxt = S_FETCH;
         S_WAIT_OUT: if (out_ready) w_state_nxt = S_FETCH;
         S_HALT:     w_state_nxt = S_HALT;
         default:    w_state_nxt = S_FETCH;
      endcase
   end

   control_decoder u_dec (
      .i_state        (r_state),
      .i_opcode       (r_opcode),
      .i_acc_zero     (acc_zero),
      .i_acc_negative (acc_negative),
      .i_in_valid     (in_valid),
      .o_ctrl         (w_ctrl)
   );

   // Reset blanks every output so no handshake can complete in that cycle.
   assign w_out = reset ? '0 : w_ctrl;

   assign in_ready     = w_out.in_ready;
   assign out_valid    = w_out.out_valid;
   assign ir_write     = w_out.ir_write;
   assign pc_increment = w_out.pc_increment;
   assign pc_load      = w_out.pc_load;
   assign sel_A        = w_out.sel_A;
   assign sel_B        = w_out.sel_B;
   assign alu_op       = w_out.alu_op;
   assign acc_write    = w_out.acc_write;
   assign mem_write    = w_out.mem_write;
   assign halted       = w_out.halted;

endmodule

// File: tb/tb_control_unit_fsm.sv
// Scoreboard bench: stimulus pushes per-cycle expected control vectors
// derived from the instruction rules; a negedge monitor pops and compares.
module tb_control_unit_fsm;

   logic        clock = 1'b0;
   logic        reset;
   logic [10:0] instruction_in;
   logic        acc_zero, acc_negative, in_valid, out_ready;
   logic        in_ready, out_valid, ir_write, pc_increment, pc_load;
   logic        sel_A, sel_B, acc_write, mem_write, halted;
   logic [1:0]  alu_op;

   int n_tests = 0;
   int n_fail  = 0;

   logic [11:0] qv[$];
   string       qt[$];

   always #5 clock = ~clock;

   control_unit_fsm dut (
      .clock          (clock),
      .reset          (reset),
      .instruction_in (instruction_in),
      .acc_zero       (acc_zero),
      .acc_negative   (acc_negative),
      .in_valid       (in_valid),
      .out_ready      (out_ready),
      .in_ready       (in_ready),
      .out_valid      (out_valid),
      .ir_write       (ir_write),
      .pc_increment   (pc_increment),
      .pc_load        (pc_load),
      .sel_A          (sel_A),
      .sel_B          (sel_B),
      .alu_op         (alu_op),
      .acc_write      (acc_write),
      .mem_write      (mem_write),
      .halted         (halted)
   );

   // Vector layout: in_ready out_valid ir_write pc_inc pc_load sel_A sel_B
   //                alu_op[1:0] acc_write mem_write halted
   function automatic logic [11:0] e_fetch();
      logic [11:0] e = '0;
      e[9] = 1'b1;
      e[8] = 1'b1;
      return e;
   endfunction

   function automatic logic [11:0] e_dec(input logic [3:0] op);
      logic [11:0] e = '0;
      e[5]   = (op == 4'd3) || (op == 4'd5) || (op == 4'd7);
      e[4:3] = (op == 4'd4 || op == 4'd5) ? 2'd1 :
               (op == 4'd6 || op == 4'd7) ? 2'd2 : 2'd0;
      return e;
   endfunction

   function automatic logic [11:0] e_exec(input logic [3:0] op, input logic z, input logic n);
      logic [11:0] e = e_dec(op);
      e[2] = (op >= 4'd2) && (op <= 4'd7);
      e[1] = (op == 4'd1);
      e[7] = (op == 4'd12) || (op == 4'd10 && z) || (op == 4'd11 && n);
      return e;
   endfunction

   function automatic logic [11:0] e_in(input logic v);
      logic [11:0] e = '0;
      e[11] = 1'b1;
      e[6]  = 1'b1;
      e[2]  = v;
      return e;
   endfunction

   function automatic logic [11:0] e_bit(input int b);
      logic [11:0] e = '0;
      e[b] = 1'b1;
      return e;
   endfunction

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   task automatic cyc(input logic rst, input logic [10:0] ins, input logic z, input logic n,
                      input logic iv, input logic ordy, input logic [11:0] e, input string tag);
      reset          = rst;
      instruction_in = ins;
      acc_zero       = z;
      acc_negative   = n;
      in_valid       = iv;
      out_ready      = ordy;
      qv.push_back(e);
      qt.push_back(tag);
      @(posedge clock);
      #1;
   endtask

   task automatic run_instr(input logic [3:0] op, input int dly, input logic z, input logic n);
      cyc(1'b0, {op, 7'($urandom)}, rb(), rb(), rb(), rb(), e_fetch(), "fetch");
      cyc(1'b0, 11'($urandom), rb(), rb(), rb(), rb(), e_dec(op), "decode");
      case (op)
         4'd0: begin
            for (int i = 0; i < dly + 10; i++)
               cyc(1'b0, 11'($urandom), rb(), rb(), rb(), rb(), e_bit(0), "halt");
            cyc(1'b1, 11'($urandom), rb(), rb(), 1'b1, 1'b1, 12'd0, "reset_from_halt");
         end
         4'd8: begin
            for (int i = 0; i < dly; i++)
               cyc(1'b0, 11'($urandom), rb(), rb(), 1'b0, rb(), e_in(1'b0), "wait_in");
            cyc(1'b0, 11'($urandom), rb(), rb(), 1'b1, rb(), e_in(1'b1), "in_handshake");
         end
         4'd9: begin
            for (int i = 0; i < dly; i++)
               cyc(1'b0, 11'($urandom), rb(), rb(), rb(), 1'b0, e_bit(10), "wait_out");
            cyc(1'b0, 11'($urandom), rb(), rb(), rb(), 1'b1, e_bit(10), "out_handshake");
         end
         default:
            cyc(1'b0, 11'($urandom), z, n, rb(), rb(), e_exec(op, z, n), "exec");
      endcase
   endtask

   always @(negedge clock) begin
      if (qv.size() > 0) begin
         logic [11:0] exp_v, act_v;
         string       tag;
         exp_v = qv.pop_front();
         tag   = qt.pop_front();
         act_v = {in_ready, out_valid, ir_write, pc_increment, pc_load, sel_A, sel_B,
                  alu_op, acc_write, mem_write, halted};
         n_tests++;
         if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b expected %b", tag, $time, act_v, exp_v);
         end
      end
   end

   initial begin
      logic [3:0] op;
      reset = 1'b1; instruction_in = '0; acc_zero = 1'b0; acc_negative = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clock);
      #1;
      cyc(1'b1, 11'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, 12'd0, "reset0");
      cyc(1'b1, 11'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, 12'd0, "reset1");

      run_instr(4'd3, 0, 1'b0, 1'b0);   // LDI
      run_instr(4'd4, 0, 1'b1, 1'b1);   // ADD
      run_instr(4'd8, 3, 1'b0, 1'b0);   // IN, valid after 3 cycles
      run_instr(4'd10, 0, 1'b1, 1'b0);  // BEQ taken
      run_instr(4'd10, 0, 1'b0, 1'b1);  // BEQ not taken
      run_instr(4'd11, 0, 1'b0, 1'b1);  // BLT taken
      run_instr(4'd1, 0, 1'b0, 1'b0);   // STO
      run_instr(4'd12, 0, 1'b0, 1'b0);  // JMP

      // OUT stalled two cycles, then reset lands while the sink is ready
      cyc(1'b0, {4'd9, 7'($urandom)}, rb(), rb(), rb(), rb(), e_fetch(), "fetch");
      cyc(1'b0, 11'($urandom), rb(), rb(), rb(), rb(), e_dec(4'd9), "decode");
      cyc(1'b0, 11'($urandom), rb(), rb(), rb(), 1'b0, e_bit(10), "wait_out");
      cyc(1'b0, 11'($urandom), rb(), rb(), rb(), 1'b0, e_bit(10), "wait_out");
      cyc(1'b1, 11'($urandom), rb(), rb(), 1'b1, 1'b1, 12'd0, "reset_mid_out");

      run_instr(4'd0, 2, 1'b0, 1'b0);   // HLT then reset

      for (int k = 0; k < 250; k++) begin
         op = 4'($urandom);
         if (op == 4'd0 && $urandom_range(0, 3) != 0) op = 4'd15;
         run_instr(op, int'($urandom_range(0, 3)), rb(), rb());
      end

      @(negedge clock);
      @(negedge clock);
      n_tests++;
      if (qv.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", qv.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
